// File: rtl/clk_freq_meter.sv
// Gated frequency meter: counts rising edges of an asynchronous meas_clk over a
// fixed window of GATE_CYCLES reference cycles and reports count plus flags.
`timescale 1ns/1ps
module clk_freq_meter #(
    parameter int GATE_CYCLES = 1000,
    parameter int CNT_W       = 16
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             meas_clk,
    input  logic             start,
    input  logic             continuous,
    input  logic [CNT_W-1:0] min_count,
    input  logic [CNT_W-1:0] max_count,
    output logic             busy,
    output logic [CNT_W-1:0] count_out,
    output logic             count_valid,
    output logic             in_range,
    output logic             no_clk,
    output logic             overflow
);

    localparam int GW = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_GATE, S_REPORT} state_t;

    state_t           state_q, state_d;
    logic [GW-1:0]    gate_cnt_q, gate_cnt_d;
    logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
    logic             sat_q, sat_d;
    logic             report;

    logic             s1_q, s2_q, prev_q;
    logic             edge_det;

    logic             busy_q, count_valid_q, in_range_q, no_clk_q, overflow_q;
    logic [CNT_W-1:0] count_out_q;

    // Two-flop synchronizer plus history flop; history keeps running across
    // back-to-back windows so a level held over REPORT is not re-counted.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            s1_q   <= meas_clk;
            s2_q   <= s1_q;
            prev_q <= s2_q;
        end
    end

    assign edge_det = s2_q & ~prev_q;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q    <= S_IDLE;
            gate_cnt_q <= '0;
            edge_cnt_q <= '0;
            sat_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            gate_cnt_q <= gate_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            sat_q      <= sat_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        gate_cnt_d = gate_cnt_q;
        edge_cnt_d = edge_cnt_q;
        sat_d      = sat_q;
        report     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_ARM;
                    gate_cnt_d = '0;
                end
            end
            S_ARM: begin
                edge_cnt_d = '0;
                sat_d      = 1'b0;
                if (gate_cnt_q == GW'(1)) begin
                    state_d    = S_GATE;
                    gate_cnt_d = '0;
                end else begin
                    gate_cnt_d = gate_cnt_q + GW'(1);
                end
            end
            S_GATE: begin
                if (edge_det) begin
                    if (edge_cnt_q == CNT_MAX) sat_d = 1'b1;
                    else                       edge_cnt_d = edge_cnt_q + CNT_W'(1);
                end
                // The last gate cycle's edge is folded in via edge_cnt_d below.
                if (gate_cnt_q == GATE_LAST) begin
                    state_d = S_REPORT;
                    report  = 1'b1;
                end else begin
                    gate_cnt_d = gate_cnt_q + GW'(1);
                end
            end
            S_REPORT: begin
                if (continuous) begin
                    state_d    = S_GATE;
                    gate_cnt_d = '0;
                    edge_cnt_d = '0;
                    sat_d      = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            busy_q        <= 1'b0;
            count_valid_q <= 1'b0;
            count_out_q   <= '0;
            in_range_q    <= 1'b0;
            no_clk_q      <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            busy_q        <= (state_d != S_IDLE);
            count_valid_q <= report;
            if (report) begin
                count_out_q <= edge_cnt_d;
                no_clk_q    <= (edge_cnt_d == '0);
                overflow_q  <= sat_d;
                in_range_q  <= (min_count <= max_count) &&
                               (min_count <= edge_cnt_d) && (edge_cnt_d <= max_count);
            end
        end
    end

    assign busy        = busy_q;
    assign count_out   = count_out_q;
    assign count_valid = count_valid_q;
    assign in_range    = in_range_q;
    assign no_clk      = no_clk_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_clk_freq_meter.sv
// Scoreboard bench for clk_freq_meter: 16-bit and 4-bit (saturating) instances
// share stimulus; expected strobes are derived from meas_clk period and window length.
`timescale 1ns/1ps
module tb_clk_freq_meter;
    localparam int G = 100;

    logic clk = 0, rst = 1, meas_clk = 0, start = 0, continuous = 0;
    logic [15:0] min_c = 0, max_c = 0;
    logic [3:0]  smin = 4'd0, smax = 4'd14;

    logic        busy, count_valid, in_range, no_clk, overflow;
    logic [15:0] count_out;
    logic        s_busy, s_count_valid, s_in_range, s_no_clk, s_overflow;
    logic [3:0]  s_count_out;

    clk_freq_meter #(.GATE_CYCLES(G), .CNT_W(16)) u_dut (
        .clk_in(clk), .rst(rst), .meas_clk(meas_clk), .start(start), .continuous(continuous),
        .min_count(min_c), .max_count(max_c), .busy(busy), .count_out(count_out),
        .count_valid(count_valid), .in_range(in_range), .no_clk(no_clk), .overflow(overflow));

    clk_freq_meter #(.GATE_CYCLES(G), .CNT_W(4)) u_sat (
        .clk_in(clk), .rst(rst), .meas_clk(meas_clk), .start(start), .continuous(continuous),
        .min_count(smin), .max_count(smax), .busy(s_busy), .count_out(s_count_out),
        .count_valid(s_count_valid), .in_range(s_in_range), .no_clk(s_no_clk), .overflow(s_overflow));

    always #5 clk = ~clk;

    int mhalf_ps = 20000;
    bit mstuck = 0, mlevel = 0;
    always begin
        if (mstuck) begin
            meas_clk = mlevel;
            #1;
        end else begin
            #(mhalf_ps / 1000.0);
            meas_clk = ~meas_clk;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {int cyc; int lo; int hi; bit inr; bit nclk;} exp_t;
    typedef struct {int cyc; int mode;} sexp_t;  // mode 0: timing only, 1: saturated, 2: zero
    exp_t  q[$];
    sexp_t sq[$];
    exp_t  em;
    sexp_t sem;
    int n_chk = 0, n_err = 0;

    task automatic chk(input string nm, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
        n_chk++;
        if (act < lo || act > hi) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d..%0d (cycle %0d)", nm, act, lo, hi, cyc);
        end
    endtask

    always @(negedge clk) if (!rst) begin
        if (q.size() != 0 && cyc > q[0].cyc) begin
            chk("missed_strobe", cyc, q[0].cyc);
            void'(q.pop_front());
        end
        if (count_valid) begin
            if (q.size() == 0) chk("unexpected_strobe", 1, 0);
            else begin
                em = q.pop_front();
                chk("strobe_cycle", cyc, em.cyc);
                chk_rng("count_out", int'(count_out), em.lo, em.hi);
                chk("no_clk", no_clk, em.nclk);
                chk("overflow", overflow, 0);
                chk("in_range", in_range, em.inr);
            end
        end
    end

    always @(negedge clk) if (!rst) begin
        if (sq.size() != 0 && cyc > sq[0].cyc) begin
            chk("sat_missed_strobe", cyc, sq[0].cyc);
            void'(sq.pop_front());
        end
        if (s_count_valid) begin
            if (sq.size() == 0) chk("sat_unexpected_strobe", 1, 0);
            else begin
                sem = sq.pop_front();
                chk("sat_strobe_cycle", cyc, sem.cyc);
                if (sem.mode == 1) begin
                    chk("sat_count", int'(s_count_out), 15);
                    chk("sat_overflow", s_overflow, 1);
                    chk("sat_in_range", s_in_range, 0);
                    chk("sat_no_clk", s_no_clk, 0);
                end else if (sem.mode == 2) begin
                    chk("sat_zero_count", int'(s_count_out), 0);
                    chk("sat_zero_no_clk", s_no_clk, 1);
                    chk("sat_zero_overflow", s_overflow, 0);
                    chk("sat_zero_in_range", s_in_range, 1);
                end
            end
        end
    end

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_count_out"}, int'(count_out), 0);
        chk({tag, "_count_valid"}, count_valid, 0);
        chk({tag, "_in_range"}, in_range, 0);
        chk({tag, "_no_clk"}, no_clk, 0);
        chk({tag, "_overflow"}, overflow, 0);
        chk({tag, "_sat_busy"}, s_busy, 0);
        chk({tag, "_sat_count_out"}, int'(s_count_out), 0);
        chk({tag, "_sat_overflow"}, s_overflow, 0);
    endtask

    // Set up meas_clk and thresholds; returns the expected count bounds.
    task automatic setup(input int per_ps, input bit lvl, input int mode,
                         output int lo, output int hi, output bit inr);
        int p;
        if (per_ps == 0) begin
            mstuck = 1; mlevel = lvl; lo = 0; hi = 0;
        end else begin
            mhalf_ps = per_ps / 2; mstuck = 0; p = 2 * mhalf_ps;
            lo = (G * 10000) / p - 1;
            hi = (G * 10000 + p - 1) / p + 1;
            if (lo < 0) lo = 0;
        end
        repeat (20) @(posedge clk);
        #1;
        case (mode)
            0: begin min_c = 16'(lo);     max_c = 16'(hi);      inr = 1; end
            1: begin min_c = 16'(hi + 1); max_c = 16'(hi + 10); inr = 0; end
            2: if (lo > 0) begin min_c = 0; max_c = 16'(lo - 1); inr = 0; end
               else begin min_c = 16'(hi + 5); max_c = 16'(lo); inr = 0; end
            default: begin min_c = 16'(hi + 5); max_c = 16'(lo); inr = 0; end
        endcase
    endtask

    task automatic issue_start(output int e);
        start = 1;
        @(posedge clk);
        #1;
        start = 0;
        e = cyc;
    endtask

    task automatic run_meas(input int win, input int per_ps, input bit lvl,
                            input int mode, input bit poke);
        int lo, hi, e, rlast, smode;
        bit inr;
        exp_t x;
        sexp_t sx;
        setup(per_ps, lvl, mode, lo, hi, inr);
        continuous = (win > 1);
        issue_start(e);
        smode = (per_ps == 0) ? 2 : (lo >= 16) ? 1 : 0;
        for (int i = 0; i < win; i++) begin
            x.cyc = e + G + 2 + i * (G + 1); x.lo = lo; x.hi = hi; x.inr = inr; x.nclk = (per_ps == 0);
            q.push_back(x);
            sx.cyc = x.cyc; sx.mode = smode;
            sq.push_back(sx);
        end
        rlast = e + G + 2 + (win - 1) * (G + 1);
        if (poke) begin
            wait_until(e + 52);
            start = 1;
            @(posedge clk);
            #1 start = 0;
        end
        if (win > 1) begin
            wait_until(rlast - (G + 1) + 1 + int'($urandom_range(0, G - 5)));
            continuous = 0;
        end
        wait_until(rlast + 3);
        chk("busy_after_run", busy, 0);
        chk("sat_busy_after_run", s_busy, 0);
        chk("queue_drained", q.size() + sq.size(), 0);
    endtask

    initial begin
        int lo, hi, e;
        bit inr;
        rst = 1;
        repeat (3) @(posedge clk);
        #1;
        check_cleared("reset");
        rst = 0;

        run_meas(1, 40000, 0, 0, 0);   // 25 MHz, 24..26, also saturates the 4-bit unit
        run_meas(3, 33334, 0, 0, 0);   // ~30 MHz continuous, then dropped
        run_meas(1, 0, 0, 1, 0);       // stuck low, min above zero
        run_meas(1, 0, 1, 0, 0);       // stuck high

        // Reset in the middle of a window, then a clean measurement.
        setup(40000, 0, 0, lo, hi, inr);
        issue_start(e);
        wait_until(e + 52);
        rst = 1;
        q.delete();
        sq.delete();
        @(posedge clk);
        #1 rst = 0;
        check_cleared("midrst");
        repeat (200) @(posedge clk);
        #1;
        check_cleared("midrst_idle");
        run_meas(1, 40000, 0, 0, 0);

        // Start during GATE is ignored; start with rst loses.
        run_meas(1, 50000, 0, 0, 1);
        rst = 1; start = 1;
        @(posedge clk);
        #1 rst = 0; start = 0;
        chk("rst_start_busy", busy, 0);
        @(posedge clk);
        #1;
        chk("rst_start_busy_next", busy, 0);
        chk("rst_start_sat_busy", s_busy, 0);

        run_meas(1, 40000, 0, 3, 0);   // min > max
        for (int i = 0; i < 8; i++) begin
            if ($urandom_range(0, 7) == 0)
                run_meas(int'($urandom_range(1, 2)), 0, 1'($urandom_range(0, 1)),
                         int'($urandom_range(0, 3)), 0);
            else
                run_meas(int'($urandom_range(1, 3)), 2 * int'($urandom_range(13000, 100000)), 0,
                         int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end
endmodule
